// File: rtl/memory_bus_controller_pkg.sv
// Shared encodings and address map for the memory bus controller.
package memory_bus_controller_pkg;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
    localparam logic [15:0] RAM_TOP        = 16'hBEFF;
    localparam logic [3:0]  IRQ_INDEX      = 4'd3;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_NONE  = 2'b11
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_STROBE,
        TX_WAIT_TBRE,
        TX_WAIT_TSRE
    } tx_state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_UART_DATA,
        TGT_UART_STAT
    } target_e;

    function automatic target_e decode_target(input logic [15:0] addr);
        target_e tgt;
        if (addr <= RAM_TOP)
            tgt = TGT_RAM;
        else if (addr == UART_DATA_ADDR)
            tgt = TGT_UART_DATA;
        else if (addr == UART_STAT_ADDR)
            tgt = TGT_UART_STAT;
        else
            tgt = TGT_NONE;
        return tgt;
    endfunction

endpackage

// File: rtl/memory_bus_controller_if.sv
// CPU-side data and instruction ports of the memory bus controller.
interface memory_bus_controller_if;
    logic [15:0] MeAaddr;
    logic [1:0]  MeMemControl;
    logic [15:0] MeMemResult;
    logic [15:0] AmemRead;
    logic [15:0] Baddr;
    logic [15:0] BmemRead;

    modport master (
        output MeAaddr, MeMemControl, MeMemResult, Baddr,
        input  AmemRead, BmemRead
    );

    modport slave (
        input  MeAaddr, MeMemControl, MeMemResult, Baddr,
        output AmemRead, BmemRead
    );
endinterface

// File: rtl/memory_bus_controller_uart_tx_handshake.sv
// UART transmit handshake: tracks a byte through tbre/tsre and flags writes that arrive while busy.
//  state         | meaning
//  TX_IDLE       | ready to accept a tx byte
//  TX_STROBE     | uart_wrn pulse just issued
//  TX_WAIT_TBRE  | waiting for transmit buffer to empty
//  TX_WAIT_TSRE  | waiting for shift register to empty
module uart_tx_handshake
    import memory_bus_controller_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic uart_tbre,
    input  logic uart_tsre,
    input  logic tx_write,
    input  logic status_read,
    output logic tx_ready,
    output logic tx_overrun
);

    tx_state_e  state, state_nx;
    logic [1:0] tbre_sync, tsre_sync;
    logic       tbre_s, tsre_s;

    assign tbre_s   = tbre_sync[1];
    assign tsre_s   = tsre_sync[1];
    assign tx_ready = (state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tbre_sync <= 2'b00;
            tsre_sync <= 2'b00;
            state     <= TX_IDLE;
        end else begin
            tbre_sync <= {tbre_sync[0], uart_tbre};
            tsre_sync <= {tsre_sync[0], uart_tsre};
            state     <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            TX_IDLE:      if (tx_write) state_nx = TX_STROBE;
            TX_STROBE:    state_nx = TX_WAIT_TBRE;
            TX_WAIT_TBRE: if (tbre_s) state_nx = TX_WAIT_TSRE;
            TX_WAIT_TSRE: if (tsre_s) state_nx = TX_IDLE;
            default:      state_nx = TX_IDLE;
        endcase
    end

    // A dropped write in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)
            tx_overrun <= 1'b0;
        else if (tx_write && !tx_ready)
            tx_overrun <= 1'b1;
        else if (status_read)
            tx_overrun <= 1'b0;
    end

endmodule

// File: rtl/memory_bus_controller.sv
// Decodes registered data-port requests onto data SRAM / UART, serves instructions from ram2,
// and pulses the hardware interrupt when the UART receives a byte.
module memory_bus_controller
    import memory_bus_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    memory_bus_controller_if.slave bus,
    output logic [17:0] ram1_addr,
    output logic [15:0] ram1_dout,
    output logic        ram1_drive,
    input  logic [15:0] ram1_din,
    output logic        ram1_en_n,
    output logic        ram1_oe_n,
    output logic        ram1_we_n,
    output logic [17:0] ram2_addr,
    input  logic [15:0] ram2_din,
    output logic        ram2_en_n,
    output logic        ram2_oe_n,
    output logic        ram2_we_n,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_data_ready,
    input  logic        uart_tbre,
    input  logic        uart_tsre,
    output logic        irq_req,
    output logic [3:0]  irq_index
);

    logic [15:0] addr_q, wdata_q, amem_read, rd_data;
    mem_ctrl_e   ctrl_q;
    target_e     tgt;
    logic        is_read, is_write;
    logic        tx_write, status_read, tx_ready, tx_overrun;
    logic [2:0]  dr_sync;
    logic        rx_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 16'h0000;
            ctrl_q  <= MEM_IDLE;
            wdata_q <= 16'h0000;
        end else begin
            addr_q  <= bus.MeAaddr;
            ctrl_q  <= mem_ctrl_e'(bus.MeMemControl);
            wdata_q <= bus.MeMemResult;
        end
    end

    assign tgt      = decode_target(addr_q);
    assign is_read  = (ctrl_q == MEM_READ);
    assign is_write = (ctrl_q == MEM_WRITE);
    assign rx_avail = dr_sync[1];

    always_comb begin
        ram1_en_n   = 1'b1;
        ram1_oe_n   = 1'b1;
        ram1_we_n   = 1'b1;
        ram1_drive  = 1'b0;
        ram1_dout   = 16'h0000;
        uart_rdn    = 1'b1;
        uart_wrn    = 1'b1;
        tx_write    = 1'b0;
        status_read = 1'b0;
        rd_data     = 16'h0000;
        case (tgt)
            TGT_RAM: begin
                rd_data = ram1_din;
                if (is_read) begin
                    ram1_en_n = 1'b0;
                    ram1_oe_n = 1'b0;
                end else if (is_write) begin
                    ram1_en_n  = 1'b0;
                    ram1_we_n  = 1'b0;
                    ram1_drive = 1'b1;
                    ram1_dout  = wdata_q;
                end
            end
            TGT_UART_DATA: begin
                rd_data = {8'h00, ram1_din[7:0]};
                if (is_read)
                    uart_rdn = 1'b0;
                else if (is_write) begin
                    tx_write = 1'b1;
                    // A busy transmitter drops the byte; the handshake records the overrun.
                    if (tx_ready) begin
                        ram1_drive = 1'b1;
                        ram1_dout  = {8'h00, wdata_q[7:0]};
                        uart_wrn   = 1'b0;
                    end
                end
            end
            TGT_UART_STAT: begin
                rd_data     = {13'b0, tx_overrun, rx_avail, tx_ready};
                status_read = is_read;
            end
            default: rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            amem_read <= 16'h0000;
        else if (is_read)
            amem_read <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_sync <= 3'b000;
            irq_req <= 1'b0;
        end else begin
            dr_sync <= {dr_sync[1:0], uart_data_ready};
            irq_req <= dr_sync[1] & ~dr_sync[2];
        end
    end

    uart_tx_handshake u_tx (
        .clk         (clk),
        .rst         (rst),
        .uart_tbre   (uart_tbre),
        .uart_tsre   (uart_tsre),
        .tx_write    (tx_write),
        .status_read (status_read),
        .tx_ready    (tx_ready),
        .tx_overrun  (tx_overrun)
    );

    assign bus.AmemRead = amem_read;
    assign bus.BmemRead = ram2_din;
    assign ram1_addr    = {2'b00, addr_q};
    assign ram2_addr    = {2'b00, bus.Baddr};
    assign ram2_en_n    = 1'b0;
    assign ram2_oe_n    = 1'b0;
    assign ram2_we_n    = 1'b1;
    assign irq_index    = IRQ_INDEX;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Self-checking bench for memory_bus_controller: vector table, UART corner sequences, random SRAM traffic.
module tb_memory_bus_controller;

    localparam logic [5:0] SIG_IDLE = 6'b111110;  // {en_n, oe_n, we_n, rdn, wrn, drive}
    localparam logic [5:0] SIG_RRD  = 6'b001110;
    localparam logic [5:0] SIG_RWR  = 6'b010111;
    localparam logic [5:0] SIG_URD  = 6'b111010;
    localparam logic [5:0] SIG_UWR  = 6'b111101;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_bus_controller_if bus_if();
    logic [17:0] ram1_addr, ram2_addr;
    logic [15:0] ram1_dout, ram1_din, ram2_din, uart_bus;
    logic        ram1_drive, ram1_en_n, ram1_oe_n, ram1_we_n;
    logic        ram2_en_n, ram2_oe_n, ram2_we_n;
    logic        uart_rdn, uart_wrn, uart_data_ready, uart_tbre, uart_tsre, irq_req;
    logic [3:0]  irq_index;
    logic [5:0]  sig_now;

    memory_bus_controller dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .ram1_addr(ram1_addr), .ram1_dout(ram1_dout), .ram1_drive(ram1_drive), .ram1_din(ram1_din),
        .ram1_en_n(ram1_en_n), .ram1_oe_n(ram1_oe_n), .ram1_we_n(ram1_we_n),
        .ram2_addr(ram2_addr), .ram2_din(ram2_din),
        .ram2_en_n(ram2_en_n), .ram2_oe_n(ram2_oe_n), .ram2_we_n(ram2_we_n),
        .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready),
        .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .irq_req(irq_req), .irq_index(irq_index)
    );

    assign sig_now = {ram1_en_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn, ram1_drive};

    // External SRAM device; only the low and top-of-RAM regions are exercised.
    logic [15:0] sram [0:255];
    function automatic logic [7:0] sidx(input logic [15:0] a);
        return {a[15], a[6:0]};
    endfunction
    always_comb ram1_din = (!ram1_en_n && !ram1_oe_n) ? sram[sidx(ram1_addr[15:0])] : uart_bus;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
        end else if (!ram1_en_n && !ram1_we_n && ram1_drive) begin
            sram[sidx(ram1_addr[15:0])] <= ram1_dout;
        end
    end

    int we_lo = 0, wrn_lo = 0;
    always @(negedge clk) begin
        if (!ram1_we_n) we_lo <= we_lo + 1;
        if (!uart_wrn)  wrn_lo <= wrn_lo + 1;
    end

    int n_vec = 0, n_err = 0;
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic txn(input string name, input logic [1:0] ctrl, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [5:0] exp_sig, input logic [15:0] exp_rd);
        int we0, wrn0;
        we0  = we_lo;
        wrn0 = wrn_lo;
        @(negedge clk);
        bus_if.MeMemControl = ctrl;
        bus_if.MeAaddr      = addr;
        bus_if.MeMemResult  = wdata;
        @(posedge clk); #1;
        chk({name, ".sig"}, 32'(sig_now), 32'(exp_sig));
        chk({name, ".addr"}, 32'(ram1_addr), 32'({2'b00, addr}));
        if (exp_sig[0])
            chk({name, ".dout"}, 32'(ram1_dout),
                32'((addr <= 16'hBEFF) ? wdata : {8'h00, wdata[7:0]}));
        @(negedge clk);
        bus_if.MeMemControl = 2'b00;
        @(posedge clk); #1;
        chk({name, ".rd"}, 32'(bus_if.AmemRead), 32'(exp_rd));
        chk({name, ".we_cycles"}, we_lo - we0, exp_sig[3] ? 0 : 1);
        chk({name, ".wrn_cycles"}, wrn_lo - wrn0, exp_sig[1] ? 0 : 1);
        if (ctrl == 2'b10 && addr <= 16'hBEFF) ref_mem[addr] = wdata;
    endtask

    typedef struct {
        logic [1:0]  ctrl;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [5:0]  sig;
        logic [15:0] rd;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[$];
        logic [1:0]  ctrl;
        logic [15:0] a, wd, model_last;
        logic [5:0]  es;

        rst = 1'b1;
        bus_if.MeMemControl = 2'b00;
        bus_if.MeAaddr      = 16'h0000;
        bus_if.MeMemResult  = 16'h0000;
        bus_if.Baddr        = 16'h1357;
        ram2_din            = 16'h2468;
        uart_bus            = 16'hFF5A;
        uart_data_ready     = 1'b0;
        uart_tbre           = 1'b0;
        uart_tsre           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rd", 32'(bus_if.AmemRead), 32'h0);
        chk("reset.sig", 32'(sig_now), 32'(SIG_IDLE));
        chk("reset.irq", 32'(irq_req), 32'h0);
        chk("irq_index", 32'(irq_index), 32'd3);
        chk("ram2_ctl", 32'({ram2_en_n, ram2_oe_n, ram2_we_n}), 32'b001);
        chk("ibus", 32'(bus_if.BmemRead), 32'h2468);
        chk("ram2_addr", 32'(ram2_addr), 32'h01357);
        @(negedge clk) rst = 1'b0;

        vt.push_back('{2'b10, 16'h0040, 16'h1234, SIG_RWR,  16'h0000});
        vt.push_back('{2'b01, 16'h0040, 16'h0000, SIG_RRD,  16'h1234});
        vt.push_back('{2'b10, 16'hBEFF, 16'hA5C3, SIG_RWR,  16'h1234});
        vt.push_back('{2'b01, 16'hBEFF, 16'h0000, SIG_RRD,  16'hA5C3});
        vt.push_back('{2'b01, 16'hBF02, 16'h0000, SIG_IDLE, 16'h0000});
        vt.push_back('{2'b10, 16'hBF02, 16'hBEEF, SIG_IDLE, 16'h0000});
        vt.push_back('{2'b11, 16'h0040, 16'h7777, SIG_IDLE, 16'h0000});
        vt.push_back('{2'b01, 16'h0040, 16'h0000, SIG_RRD,  16'h1234});
        vt.push_back('{2'b10, 16'hFFFF, 16'hDEAD, SIG_IDLE, 16'h1234});
        vt.push_back('{2'b01, 16'hFFFF, 16'h0000, SIG_IDLE, 16'h0000});
        vt.push_back('{2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0001});
        vt.push_back('{2'b10, 16'hBF01, 16'h00FF, SIG_IDLE, 16'h0001});
        vt.push_back('{2'b01, 16'hBF00, 16'h0000, SIG_URD,  16'h005A});
        foreach (vt[i])
            txn($sformatf("vec%0d", i), vt[i].ctrl, vt[i].addr, vt[i].wdata, vt[i].sig, vt[i].rd);

        // UART transmit through tbre then tsre
        txn("tx.write", 2'b10, 16'hBF00, 16'h0041, SIG_UWR, 16'h005A);
        repeat (5) @(posedge clk);
        txn("tx.busy", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0000);
        @(negedge clk) uart_tbre = 1'b1;
        repeat (4) @(posedge clk);
        txn("tx.wait_tsre", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0000);
        @(negedge clk) uart_tsre = 1'b1;
        repeat (4) @(posedge clk);
        txn("tx.done", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0001);

        // Overrun: second write while busy is dropped, status clears on read
        @(negedge clk) begin uart_tbre = 1'b0; uart_tsre = 1'b0; end
        repeat (3) @(posedge clk);
        txn("ovr.first", 2'b10, 16'hBF00, 16'h0042, SIG_UWR, 16'h0001);
        @(posedge clk);
        txn("ovr.second", 2'b10, 16'hBF00, 16'h0043, SIG_IDLE, 16'h0001);
        txn("ovr.stat1", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0004);
        txn("ovr.stat2", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0000);
        @(negedge clk) begin uart_tbre = 1'b1; uart_tsre = 1'b1; end
        repeat (6) @(posedge clk);

        // Receive: irq pulse three edges after the rise
        @(negedge clk) uart_data_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("irq.edge%0d", k), 32'(irq_req), (k == 3) ? 32'h1 : 32'h0);
        end
        chk("irq_index.rx", 32'(irq_index), 32'd3);
        txn("rx.stat", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0003);
        txn("rx.read", 2'b01, 16'hBF00, 16'h0000, SIG_URD, 16'h005A);
        @(negedge clk) uart_data_ready = 1'b0;
        repeat (4) @(posedge clk);

        // irq pulse coincides with a UART data read strobe
        uart_bus = 16'h33C7;
        @(negedge clk) uart_data_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) begin bus_if.MeMemControl = 2'b01; bus_if.MeAaddr = 16'hBF00; end
        @(posedge clk); #1;
        chk("irqrd.irq", 32'(irq_req), 32'h1);
        chk("irqrd.rdn", 32'(uart_rdn), 32'h0);
        @(negedge clk) bus_if.MeMemControl = 2'b00;
        @(posedge clk); #1;
        chk("irqrd.irq_off", 32'(irq_req), 32'h0);
        chk("irqrd.rd", 32'(bus_if.AmemRead), 32'h00C7);
        @(negedge clk) uart_data_ready = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during a strobe while the transmitter waits for tsre
        @(negedge clk) begin uart_tbre = 1'b0; uart_tsre = 1'b0; end
        repeat (3) @(posedge clk);
        txn("rst.tx", 2'b10, 16'hBF00, 16'h0055, SIG_UWR, 16'h00C7);
        @(negedge clk) uart_tbre = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) begin
            bus_if.MeMemControl = 2'b10; bus_if.MeAaddr = 16'h0010; bus_if.MeMemResult = 16'hBEEF;
        end
        @(posedge clk); #1;
        chk("rst.mid_sig", 32'(sig_now), 32'(SIG_RWR));
        @(negedge clk) begin rst = 1'b1; bus_if.MeMemControl = 2'b00; end
        @(posedge clk); #1;
        chk("rst.release", 32'(sig_now), 32'(SIG_IDLE));
        chk("rst.rd", 32'(bus_if.AmemRead), 32'h0);
        chk("rst.irq", 32'(irq_req), 32'h0);
        ref_mem.delete();
        @(negedge clk) rst = 1'b0;
        txn("rst.idle", 2'b01, 16'hBF01, 16'h0000, SIG_IDLE, 16'h0001);
        @(negedge clk) uart_tsre = 1'b1;

        // Random SRAM / unmapped / no-op traffic against the reference memory
        model_last = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            ctrl = (i == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    a = 16'($urandom_range(0, 63));
                2:       a = 16'hBEC0 + 16'($urandom_range(0, 63));
                default: a = 16'hBF02 + 16'($urandom_range(0, 16'h40FD));
            endcase
            if (i == 0) a = 16'h0040;
            wd = 16'($urandom);
            if (ctrl == 2'b01 && a <= 16'hBEFF) begin
                es = SIG_RRD;
                model_last = mem_val(a);
            end else if (ctrl == 2'b10 && a <= 16'hBEFF) begin
                es = SIG_RWR;
            end else begin
                es = SIG_IDLE;
                if (ctrl == 2'b01) model_last = 16'h0000;
            end
            bus_if.Baddr = 16'($urandom);
            ram2_din     = 16'($urandom);
            uart_bus     = 16'($urandom);
            txn($sformatf("rand%0d", i), ctrl, a, wd, es, model_last);
            chk("rand.ibus", 32'(bus_if.BmemRead), 32'(ram2_din));
            chk("rand.ram2_addr", 32'(ram2_addr), 32'({2'b00, bus_if.Baddr}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
